// File: rtl/axi_lite_master_if.sv
// Bundle of front-end request/response and AXI-Lite channel signals
// for axi_lite_master. master = the bridge, slave = whatever drives it.
interface axi_lite_master_if;
    logic         req_valid;
    logic         req_ready;
    logic         req_we;
    logic [31:0]  req_addr;
    logic [127:0] req_wdata;
    logic [15:0]  req_wstrb;
    logic         resp_valid;
    logic         resp_ready;
    logic [127:0] resp_rdata;
    logic         resp_we;
    logic         resp_err;
    logic [31:0]  readAddr_addr;
    logic         readAddr_valid;
    logic         readAddr_ready;
    logic [127:0] readData_data;
    logic         readData_valid;
    logic         readData_ready;
    logic [31:0]  writeAddr_addr;
    logic         writeAddr_valid;
    logic         writeAddr_ready;
    logic [127:0] writeData_data;
    logic [15:0]  writeData_strb;
    logic         writeData_valid;
    logic         writeData_ready;
    logic [31:0]  writeResp_msg;
    logic         writeResp_valid;
    logic         writeResp_ready;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata, req_wstrb, resp_ready,
               readAddr_ready, readData_data, readData_valid,
               writeAddr_ready, writeData_ready, writeResp_msg, writeResp_valid,
        output req_ready, resp_valid, resp_rdata, resp_we, resp_err,
               readAddr_addr, readAddr_valid, readData_ready,
               writeAddr_addr, writeAddr_valid, writeData_data, writeData_strb,
               writeData_valid, writeResp_ready
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata, req_wstrb, resp_ready,
               readAddr_ready, readData_data, readData_valid,
               writeAddr_ready, writeData_ready, writeResp_msg, writeResp_valid,
        input  req_ready, resp_valid, resp_rdata, resp_we, resp_err,
               readAddr_addr, readAddr_valid, readData_ready,
               writeAddr_addr, writeAddr_valid, writeData_data, writeData_strb,
               writeData_valid, writeResp_ready
    );
endinterface

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI-Lite master: turns one front-end request into an
// AR/R or AW+W/B exchange and returns one response, with a timeout on the
// slave's R/B response.
module axi_lite_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               rst,
    axi_lite_master_if.master  bus
);
    typedef enum logic [2:0] {IDLE, RADDR, RDATA, WREQ, WRESP, RESP} state_t;

    // Counter value on the last permitted wait cycle; a miss there times out.
    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT_CYCLES - 1);

    state_t       state, nextState;
    logic [7:0]   waitCnt;
    logic         awDone, wDone;
    logic [31:0]  addrReg;
    logic [127:0] wdataReg;
    logic [15:0]  wstrbReg;
    logic [127:0] respRdata;
    logic         respWe, respErr;
    logic         accept, arHs, rHs, awHs, wHs, bHs, timeout;
    logic         unusedMsg;

    // The B message carries nothing this block needs.
    assign unusedMsg = ^bus.writeResp_msg;

    // State register; reset abandons whatever is in flight.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nextState;
    end

    // Handshake decode and next-state selection.
    always_comb begin
        nextState = state;
        accept    = (state == IDLE)  && bus.req_valid;
        arHs      = (state == RADDR) && bus.readAddr_ready;
        rHs       = (state == RDATA) && bus.readData_valid;
        awHs      = (state == WREQ)  && !awDone && bus.writeAddr_ready;
        wHs       = (state == WREQ)  && !wDone  && bus.writeData_ready;
        bHs       = (state == WRESP) && bus.writeResp_valid;
        // A handshake on the last wait cycle still wins over the timeout.
        timeout   = (((state == RDATA) && !bus.readData_valid) ||
                     ((state == WRESP) && !bus.writeResp_valid)) &&
                    (waitCnt == LAST_WAIT);
        case (state)
            IDLE:    if (accept) nextState = bus.req_we ? WREQ : RADDR;
            RADDR:   if (arHs) nextState = RDATA;
            RDATA:   if (rHs || timeout) nextState = RESP;
            WREQ:    if ((awDone || awHs) && (wDone || wHs)) nextState = WRESP;
            WRESP:   if (bHs || timeout) nextState = RESP;
            RESP:    if (bus.resp_ready) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Request fields are only looked at while the matching valid is high.
    always_ff @(posedge clk) begin
        if (accept) begin
            addrReg  <= bus.req_addr;
            wdataReg <= bus.req_wdata;
            wstrbReg <= bus.req_wstrb;
        end
    end

    // Channel-done flags, wait counter and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            waitCnt   <= '0;
            awDone    <= 1'b0;
            wDone     <= 1'b0;
            respRdata <= '0;
            respWe    <= 1'b0;
            respErr   <= 1'b0;
        end else begin
            if (accept) begin
                respWe <= bus.req_we;
                awDone <= 1'b0;
                wDone  <= 1'b0;
            end
            if (awHs) awDone <= 1'b1;
            if (wHs)  wDone  <= 1'b1;
            if (nextState != state)
                waitCnt <= '0;
            else if (state == RDATA || state == WRESP)
                waitCnt <= waitCnt + 8'd1;
            if (rHs) begin
                respRdata <= bus.readData_data;
                respErr   <= 1'b0;
            end else if (bHs) begin
                respRdata <= '0;
                respErr   <= 1'b0;
            end else if (timeout) begin
                respRdata <= '0;
                respErr   <= 1'b1;
            end
        end
    end

    assign bus.req_ready       = (state == IDLE);
    assign bus.readAddr_valid  = (state == RADDR);
    assign bus.readAddr_addr   = addrReg;
    assign bus.readData_ready  = (state == RDATA);
    assign bus.writeAddr_valid = (state == WREQ) && !awDone;
    assign bus.writeAddr_addr  = addrReg;
    assign bus.writeData_valid = (state == WREQ) && !wDone;
    assign bus.writeData_data  = wdataReg;
    assign bus.writeData_strb  = wstrbReg;
    assign bus.writeResp_ready = (state == WRESP);
    assign bus.resp_valid      = (state == RESP);
    assign bus.resp_rdata      = respRdata;
    assign bus.resp_we         = respWe;
    assign bus.resp_err        = respErr;
endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench for axi_lite_master (TIMEOUT_CYCLES = 4).
module tb_axi_lite_master;
    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    axi_lite_master_if bus ();

    axi_lite_master #(.TIMEOUT_CYCLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [127:0] RD0 = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] RD1 = 128'hdeadbeef0123456789abcdefcafef00d;
    localparam logic [127:0] RD2 = 128'h11112222333344445555666677778888;
    localparam logic [127:0] WD0 = 128'hffeeddccbbaa99887766554433221100;

    // Outputs are sampled 1 time unit after the edge; inputs change there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        bus.req_valid = 0; bus.req_we = 0; bus.req_addr = '0; bus.req_wdata = '0;
        bus.req_wstrb = '0; bus.resp_ready = 0;
        bus.readAddr_ready = 0; bus.readData_data = '0; bus.readData_valid = 0;
        bus.writeAddr_ready = 0; bus.writeData_ready = 0;
        bus.writeResp_msg = '0; bus.writeResp_valid = 0;
    endtask

    task automatic test_reset();
        rst = 1; idleInputs();
        tick(); tick();
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready: got %b want 1", bus.req_ready); end
        checks++; if ({bus.resp_valid, bus.readAddr_valid, bus.readData_ready, bus.writeAddr_valid,
                       bus.writeData_valid, bus.writeResp_ready} !== 6'b0) begin errors++;
            $display("FAIL rst_valids: got %b want 000000", {bus.resp_valid, bus.readAddr_valid, bus.readData_ready,
                     bus.writeAddr_valid, bus.writeData_valid, bus.writeResp_ready}); end
        checks++; if ({bus.resp_we, bus.resp_err} !== 2'b00 || bus.resp_rdata !== '0) begin errors++;
            $display("FAIL rst_resp: got we=%b err=%b rdata=%h want 0", bus.resp_we, bus.resp_err, bus.resp_rdata); end
        rst = 0;
        tick();
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_release: got %b want 1", bus.req_ready); end
    endtask

    task automatic test_read(input logic [31:0] addr, input logic [127:0] data, input string tag);
        bus.req_valid = 1; bus.req_we = 0; bus.req_addr = addr;
        bus.readAddr_ready = 1; bus.readData_valid = 1; bus.readData_data = data;
        tick();
        checks++; if (bus.readAddr_valid !== 1'b1 || bus.readAddr_addr !== addr || bus.req_ready !== 1'b0) begin errors++;
            $display("FAIL %s_ar: got v=%b a=%h rr=%b want 1 %h 0", tag, bus.readAddr_valid, bus.readAddr_addr, bus.req_ready, addr); end
        bus.req_valid = 0;
        tick();
        checks++; if (bus.readAddr_valid !== 1'b0 || bus.readData_ready !== 1'b1) begin errors++;
            $display("FAIL %s_r: got arv=%b rrdy=%b want 0 1", tag, bus.readAddr_valid, bus.readData_ready); end
        tick();
        checks++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== data || bus.resp_err !== 1'b0 || bus.resp_we !== 1'b0) begin errors++;
            $display("FAIL %s_resp: got v=%b d=%h e=%b we=%b want 1 %h 0 0", tag, bus.resp_valid, bus.resp_rdata, bus.resp_err, bus.resp_we, data); end
        checks++; if (bus.readData_ready !== 1'b0) begin errors++; $display("FAIL %s_rdrop: got %b want 0", tag, bus.readData_ready); end
        idleInputs(); bus.resp_ready = 1;
        tick();
        checks++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin errors++;
            $display("FAIL %s_idle: got rv=%b rr=%b want 0 1", tag, bus.resp_valid, bus.req_ready); end
        bus.resp_ready = 0;
    endtask

    task automatic test_write_skew();
        bus.req_valid = 1; bus.req_we = 1; bus.req_addr = 32'h20; bus.req_wdata = WD0; bus.req_wstrb = 16'h00ff;
        bus.writeAddr_ready = 1; bus.writeData_ready = 0;
        tick();
        checks++; if (bus.writeAddr_valid !== 1'b1 || bus.writeData_valid !== 1'b1 || bus.writeAddr_addr !== 32'h20 ||
                      bus.writeData_data !== WD0 || bus.writeData_strb !== 16'h00ff) begin errors++;
            $display("FAIL wr_entry: got awv=%b wv=%b a=%h d=%h s=%h", bus.writeAddr_valid, bus.writeData_valid,
                     bus.writeAddr_addr, bus.writeData_data, bus.writeData_strb); end
        bus.req_valid = 0;
        tick();
        bus.writeAddr_ready = 0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (bus.writeAddr_valid !== 1'b0 || bus.writeData_valid !== 1'b1) begin errors++;
                $display("FAIL wr_skew%0d: got awv=%b wv=%b want 0 1", i, bus.writeAddr_valid, bus.writeData_valid); end
            if (i == 2) bus.writeData_ready = 1;
            else tick();
        end
        tick();
        bus.writeData_ready = 0;
        checks++; if (bus.writeData_valid !== 1'b0 || bus.writeResp_ready !== 1'b1) begin errors++;
            $display("FAIL wr_wresp: got wv=%b brdy=%b want 0 1", bus.writeData_valid, bus.writeResp_ready); end
        bus.writeResp_valid = 1; bus.writeResp_msg = 32'hbad0bad0;
        tick();
        checks++; if (bus.resp_valid !== 1'b1 || bus.resp_we !== 1'b1 || bus.resp_err !== 1'b0 || bus.resp_rdata !== '0) begin errors++;
            $display("FAIL wr_resp: got v=%b we=%b e=%b d=%h want 1 1 0 0", bus.resp_valid, bus.resp_we, bus.resp_err, bus.resp_rdata); end
        idleInputs(); bus.resp_ready = 1;
        tick();
        bus.resp_ready = 0;
    endtask

    task automatic test_backpressure();
        bus.req_valid = 1; bus.req_we = 0; bus.req_addr = 32'h44;
        tick();
        // A competing request while busy must be ignored.
        bus.req_we = 1; bus.req_addr = 32'h99;
        for (int i = 0; i < 10; i++) begin
            checks++; if (bus.readAddr_valid !== 1'b1 || bus.readAddr_addr !== 32'h44) begin errors++;
                $display("FAIL bp_ar%0d: got v=%b a=%h want 1 44", i, bus.readAddr_valid, bus.readAddr_addr); end
            tick();
        end
        bus.req_valid = 0;
        bus.readAddr_ready = 1;
        tick();
        bus.readAddr_ready = 0;
        // Three empty RDATA cycles, then R arrives on the last allowed one.
        for (int i = 0; i < 3; i++) begin
            checks++; if (bus.readData_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin errors++;
                $display("FAIL bp_rwait%0d: got rrdy=%b rv=%b want 1 0", i, bus.readData_ready, bus.resp_valid); end
            tick();
        end
        bus.readData_valid = 1; bus.readData_data = RD1;
        tick();
        bus.readData_valid = 0; bus.readData_data = '0;
        for (int i = 0; i < 5; i++) begin
            checks++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== RD1 || bus.resp_err !== 1'b0 || bus.resp_we !== 1'b0) begin errors++;
                $display("FAIL bp_resp%0d: got v=%b d=%h e=%b we=%b", i, bus.resp_valid, bus.resp_rdata, bus.resp_err, bus.resp_we); end
            tick();
        end
        bus.resp_ready = 1;
        tick();
        bus.resp_ready = 0;
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL bp_idle: got %b want 1", bus.req_ready); end
    endtask

    task automatic test_timeout();
        // Write with zero strobes, AW and W both ready on the first WREQ cycle.
        bus.req_valid = 1; bus.req_we = 1; bus.req_addr = 32'h30; bus.req_wdata = WD0; bus.req_wstrb = 16'h0000;
        bus.writeAddr_ready = 1; bus.writeData_ready = 1;
        tick();
        bus.req_valid = 0;
        checks++; if (bus.writeAddr_valid !== 1'b1 || bus.writeData_valid !== 1'b1 || bus.writeData_strb !== 16'h0000 ||
                      bus.writeData_data !== WD0 || bus.writeAddr_addr !== 32'h30) begin errors++;
            $display("FAIL to_wreq: got awv=%b wv=%b s=%h d=%h a=%h", bus.writeAddr_valid, bus.writeData_valid,
                     bus.writeData_strb, bus.writeData_data, bus.writeAddr_addr); end
        tick();
        bus.writeAddr_ready = 0; bus.writeData_ready = 0;
        checks++; if (bus.writeAddr_valid !== 1'b0 || bus.writeData_valid !== 1'b0 || bus.writeResp_ready !== 1'b1) begin errors++;
            $display("FAIL to_both: got awv=%b wv=%b brdy=%b want 0 0 1", bus.writeAddr_valid, bus.writeData_valid, bus.writeResp_ready); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.writeResp_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin errors++;
                $display("FAIL to_bwait%0d: got brdy=%b rv=%b want 1 0", i, bus.writeResp_ready, bus.resp_valid); end
            tick();
        end
        checks++; if (bus.resp_valid !== 1'b1 || bus.resp_err !== 1'b1 || bus.resp_we !== 1'b1 ||
                      bus.resp_rdata !== '0 || bus.writeResp_ready !== 1'b0) begin errors++;
            $display("FAIL to_wr: got v=%b e=%b we=%b d=%h brdy=%b want 1 1 1 0 0", bus.resp_valid, bus.resp_err,
                     bus.resp_we, bus.resp_rdata, bus.writeResp_ready); end
        bus.resp_ready = 1;
        tick();
        bus.resp_ready = 0;
        // Read whose R never arrives.
        bus.req_valid = 1; bus.req_we = 0; bus.req_addr = 32'h34; bus.readAddr_ready = 1;
        tick();
        bus.req_valid = 0;
        tick();
        bus.readAddr_ready = 0;
        for (int i = 0; i < 4; i++) tick();
        checks++; if (bus.resp_valid !== 1'b1 || bus.resp_err !== 1'b1 || bus.resp_we !== 1'b0 ||
                      bus.resp_rdata !== '0 || bus.readData_ready !== 1'b0) begin errors++;
            $display("FAIL to_rd: got v=%b e=%b we=%b d=%h rrdy=%b want 1 1 0 0 0", bus.resp_valid, bus.resp_err,
                     bus.resp_we, bus.resp_rdata, bus.readData_ready); end
        bus.resp_ready = 1;
        tick();
        bus.resp_ready = 0;
    endtask

    task automatic test_reset_in_flight();
        bus.req_valid = 1; bus.req_we = 0; bus.req_addr = 32'h50; bus.readAddr_ready = 1;
        tick();
        bus.req_valid = 0;
        tick();
        bus.readAddr_ready = 0;
        checks++; if (bus.readData_ready !== 1'b1) begin errors++; $display("FAIL rif_rdata: got %b want 1", bus.readData_ready); end
        rst = 1;
        tick();
        rst = 0;
        checks++; if (bus.readData_ready !== 1'b0 || bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || bus.resp_err !== 1'b0) begin errors++;
            $display("FAIL rif_rst: got rrdy=%b rr=%b rv=%b e=%b want 0 1 0 0", bus.readData_ready, bus.req_ready,
                     bus.resp_valid, bus.resp_err); end
        test_read(32'h60, RD2, "rif_rd");
    endtask

    initial begin
        rst = 1;
        idleInputs();
        test_reset();
        test_read(32'h10, RD0, "rd");
        test_write_skew();
        test_backpressure();
        test_timeout();
        test_reset_in_flight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
